// File: rtl/ps2_scan_decoder.sv
// Scan Code Set 2 decoder: folds E0/F0/E1 prefix sequences into single key events,
// queues them in a show-ahead FIFO and tracks the live Shift/Ctrl/Alt state.
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scanCode,
  input  logic       scanCodeReady,
  output logic [9:0] eventData,
  output logic       eventValid,
  input  logic       eventRead,
  output logic       shiftDown,
  output logic       ctrlDown,
  output logic       altDown,
  output logic       overflow,
  input  logic       clearOverflow
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t     state, state_nxt;
  logic [2:0] pause_cnt, pause_cnt_nxt;
  logic       is_ctrl;
  logic       emit;
  logic [9:0] emit_data;

  logic [9:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, pop, push_ok, drop;
  logic           l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt;

  always_comb begin
    case (scanCode)
      8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'h00, 8'hFF: is_ctrl = 1'b1;
      default:                                          is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pause_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_cnt_nxt;
    end
  end

  // Pause bytes are swallowed without decoding; control bytes abort any prefix.
  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    emit          = 1'b0;
    emit_data     = {2'b00, scanCode};
    if (scanCodeReady) begin
      if (state == PAUSE) begin
        if (pause_cnt <= 3'd1) begin
          emit          = 1'b1;
          emit_data     = 10'h0E1;
          state_nxt     = IDLE;
          pause_cnt_nxt = 3'd0;
        end else begin
          pause_cnt_nxt = pause_cnt - 3'd1;
        end
      end else if (is_ctrl) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (scanCode == 8'hE0) state_nxt = EXT;
            else if (scanCode == 8'hF0) state_nxt = BRK;
            else if (scanCode == 8'hE1) begin
              state_nxt     = PAUSE;
              pause_cnt_nxt = 3'd7;
            end else emit = 1'b1;
          end
          EXT: begin
            if (scanCode == 8'hF0) state_nxt = EXT_BRK;
            else if (scanCode != 8'hE0) begin
              emit      = 1'b1;
              emit_data = {2'b10, scanCode};
              state_nxt = IDLE;
            end
          end
          BRK: begin
            if (scanCode != 8'hF0) begin
              emit      = 1'b1;
              emit_data = {2'b01, scanCode};
              state_nxt = IDLE;
            end
          end
          EXT_BRK: begin
            emit      = 1'b1;
            emit_data = {2'b11, scanCode};
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = eventRead && !fifo_empty;
  assign push_ok    = emit && (!fifo_full || pop);
  assign drop       = emit && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (drop)    overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= emit_data;
  end

  assign eventValid = !fifo_empty;
  assign eventData  = fifo_empty ? 10'h000 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_shift <= 1'b0;
      r_shift <= 1'b0;
      l_ctrl  <= 1'b0;
      r_ctrl  <= 1'b0;
      l_alt   <= 1'b0;
      r_alt   <= 1'b0;
    end else if (emit) begin
      case ({emit_data[9], emit_data[7:0]})
        9'h012:  l_shift <= !emit_data[8];
        9'h059:  r_shift <= !emit_data[8];
        9'h014:  l_ctrl  <= !emit_data[8];
        9'h114:  r_ctrl  <= !emit_data[8];
        9'h011:  l_alt   <= !emit_data[8];
        9'h111:  r_alt   <= !emit_data[8];
        default: ;
      endcase
    end
  end

  assign shiftDown = l_shift | r_shift;
  assign ctrlDown  = l_ctrl | r_ctrl;
  assign altDown   = l_alt | r_alt;

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver and consumes its 8-bit scanCode / 1-cycle scanCodeReady pulse in the system clk domain.
- Decodes Scan Code Set 2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events {extended, release, code}.
- Buffers the events in a show-ahead FIFO for the CPU/bus side and tracks the live Shift/Ctrl/Alt modifier state.

Parameters:
- FIFO_DEPTH, 8, number of event entries; power of 2, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived; do not override).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- scanCode  input  8  byte from the receiver; sampled only when scanCodeReady=1.
- scanCodeReady  input  1  single-cycle strobe, synchronous to clk.
- eventData  output  10  head entry: [9]=extended, [8]=release, [7:0]=key code. Valid only when eventValid=1.
- eventValid  output  1  FIFO non-empty.
- eventRead  input  1  pop request; takes effect only when eventValid=1.
- shiftDown  output  1  left (12) or right (59) Shift is held.
- ctrlDown  output  1  left (14) or right (E0 14) Ctrl is held.
- altDown  output  1  left (11) or right (E0 11) Alt is held.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- clearOverflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst=0):
  - FSM goes to IDLE; FIFO is emptied.
  - eventData=0, eventValid=0, shiftDown=ctrlDown=altDown=0, overflow=0.
  - The pause counter is 0. Reset in the middle of a prefix sequence discards the partial sequence.
- FSM:
  - States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping bytes).
  - The FSM advances only on cycles with scanCodeReady=1.
- Transitions:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE with the pause counter loaded to 7; any other byte emits {0,0,byte}.
  - EXT: F0->EXT_BRK; any other byte emits {1,0,byte} ->IDLE.
  - BRK: any byte emits {0,1,byte} ->IDLE.
  - EXT_BRK: any byte emits {1,1,byte} ->IDLE.
  - PAUSE: decrement the counter on each byte. When the counter reaches 0 on a byte, emit {0,0,E1} and go ->IDLE. Bytes inside PAUSE are never decoded, including E0, F0 and E1.
- Control bytes:
  - AA, FA, EE, FC, FD, 00 and FF received in IDLE, EXT, BRK or EXT_BRK produce no event and return the FSM to IDLE.
  - A second E0 while in EXT stays in EXT. A second F0 while in BRK stays in BRK.
- Latency: a scanCodeReady pulse in cycle N that completes an event has the entry written at the end of N. eventValid and the modifier outputs reflect it in N+1.
- Modifiers:
  - Set on make and cleared on break of the matching code/extended pair.
  - Left and right keys are tracked separately; each output is the OR of its left and right bits.
  - Modifiers update even when the event is dropped because the FIFO is full.
- FIFO:
  - Show-ahead: eventData always shows the head entry.
  - A pop (eventRead=1 while eventValid=1) advances the head at the clock edge; eventRead while empty is ignored.
  - Push while full: the event is dropped, overflow sets, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, and the count is unchanged.
  - Push and pop in the same cycle while empty: no pop; the entry is written and eventValid=1 in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit or an occupancy counter.
- overflow:
  - Cleared by clearOverflow=1.
  - If clearOverflow and a new drop occur in the same cycle, the set wins.
- eventData is 0 while the FIFO is empty, both after reset and after the last pop.

Test Plan:
- Bytes 1C -> one event 0x01C; shiftDown=0; eventValid rises in the cycle after the strobe. Pop -> eventValid=0, eventData=0.
- Bytes 12, 1C, F0 1C, F0 12 -> events 0x012, 0x01C, 0x11C, 0x112. shiftDown=1 from the cycle after the first 12 until the cycle after the final 12.
- Bytes E0 75, E0 F0 75, E0 14 -> events 0x275, 0x375, 0x214. ctrlDown=1 after E0 14. Then bytes 14, F0 14 -> ctrlDown stays 1 because right Ctrl is still held.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x0E1; no modifier change. Bytes FA and AA in IDLE, and E0 followed by AA -> no events, FSM returns to IDLE.
- FIFO_DEPTH=8: push 9 distinct makes with no reads -> the first 8 are retained in order, the 9th is dropped, overflow=1. Push and pop in the same cycle while full -> count stays 8. clearOverflow -> overflow=0.
- Drive E0 F0, then assert rst=0 mid-sequence; after release send 1C -> event 0x01C (no stale extended/release bits), FIFO previously emptied, all modifier outputs 0.
